// File: rtl/timer_pkg.sv
// ----------------------------------------------------------------------------
// timer_pkg
// Shared definitions for the stopwatch control block:
//   state_t    - 2-bit FSM encoding (IDLE=00, RUN=01, PAUSE=10, DONE=11)
//   cnt_width  - width of a counter that must hold 0..n-1 (minimum 1 bit)
// ----------------------------------------------------------------------------
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    // Bits needed for a counter spanning 0..n-1; never returns 0.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/timer_ctrl_if.sv
// ----------------------------------------------------------------------------
// timer_ctrl_if
// Bundles the key inputs, datapath feedback and control outputs of
// timer_ctrl.
//   key_start_n, key_clr_n : raw active-low push-buttons (asynchronous)
//   at_max                 : datapath holds 59:59
//   tick_en, clr_pulse     : one-cycle strobes to the datapath
//   running, state         : FSM status (state doubles as debug visibility)
// Handshake semantics: there is no valid/ready pair here; tick_en and
// clr_pulse are single-cycle strobes that the datapath must consume on the
// cycle they are high, and at_max is a level sampled every cycle.
// Modports: slave = timer_ctrl, master = board / datapath side.
// ----------------------------------------------------------------------------
interface timer_ctrl_if;

    logic       key_start_n;
    logic       key_clr_n;
    logic       at_max;
    logic       tick_en;
    logic       clr_pulse;
    logic       running;
    logic [1:0] state;

    modport slave (
        input  key_start_n,
        input  key_clr_n,
        input  at_max,
        output tick_en,
        output clr_pulse,
        output running,
        output state
    );

    modport master (
        output key_start_n,
        output key_clr_n,
        output at_max,
        input  tick_en,
        input  clr_pulse,
        input  running,
        input  state
    );

endinterface

// File: rtl/key_debounce.sv
// ----------------------------------------------------------------------------
// key_debounce
// 2-FF synchronizer, counter debounce and press (1->0) pulse for one
// active-low push-button.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   key_n_i       : raw key level, asynchronous to clk_i
//   press_o       : one-cycle pulse after the debounced level falls
// The debounced level changes only after DB_CYCLES consecutive samples that
// differ from it; release produces no pulse.
// ----------------------------------------------------------------------------
module key_debounce
    import timer_pkg::*;
#(
    parameter int DB_CYCLES = 1000000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic key_n_i,
    output logic press_o
);

    localparam int            CW      = cnt_width(DB_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          db_q, db_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          press_q, press_d;

    always_comb begin
        db_d    = db_q;
        cnt_d   = cnt_q;
        if (sync2_q == db_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            db_d  = sync2_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
        // Registered so the pulse lands in the cycle after the level falls.
        press_d = db_q & ~db_d;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            db_q    <= 1'b1;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= key_n_i;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/timer_ctrl.sv
// ----------------------------------------------------------------------------
// timer_ctrl
// Control and sequencing for the mm:ss stopwatch datapath: key conditioning,
// IDLE/RUN/PAUSE/DONE state machine, tick prescaler and clear strobe.
//   CLOCK_50 : system clock
//   RESET_N  : asynchronous active-low reset
//   bus      : timer_ctrl_if.slave (keys, at_max in; tick_en, clr_pulse,
//              running, state out). All outputs are registered.
// DIV = CLK_HZ/TICK_HZ must be at least 2.
// ----------------------------------------------------------------------------
module timer_ctrl
    import timer_pkg::*;
#(
    parameter int CLK_HZ    = 50000000,
    parameter int TICK_HZ   = 1,
    parameter int DB_CYCLES = 1000000,
    parameter bit WRAP      = 1'b1
) (
    input  logic         CLOCK_50,
    input  logic         RESET_N,
    timer_ctrl_if.slave  bus
);

    localparam int            DIV       = CLK_HZ / TICK_HZ;
    localparam int            PW        = cnt_width(DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

    logic          start_ev, clr_ev;
    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          tick_q, tick_d;
    logic          clr_q, clr_d;
    logic          running_q;

    key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_start (
        .clk_i   (CLOCK_50),
        .rst_ni  (RESET_N),
        .key_n_i (bus.key_start_n),
        .press_o (start_ev)
    );

    key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_clr (
        .clk_i   (CLOCK_50),
        .rst_ni  (RESET_N),
        .key_n_i (bus.key_clr_n),
        .press_o (clr_ev)
    );

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        tick_d  = 1'b0;
        clr_d   = 1'b0;
        if (clr_ev) begin
            // Clear outranks a simultaneous start, which is simply dropped.
            state_d = ST_IDLE;
            presc_d = '0;
            clr_d   = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_ev) begin
                        state_d = ST_RUN;
                        presc_d = '0;
                    end
                end
                ST_RUN: begin
                    if (presc_q == PRESC_MAX) begin
                        presc_d = '0;
                        if (!WRAP && bus.at_max) begin
                            state_d = ST_DONE;
                        end else begin
                            // Tick still goes out when pausing on terminal count.
                            tick_d = 1'b1;
                            if (start_ev) state_d = ST_PAUSE;
                        end
                    end else if (start_ev) begin
                        // Freeze the prescaler at its current value so the
                        // fractional second resumes exactly where it left off.
                        state_d = ST_PAUSE;
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
                ST_PAUSE: begin
                    if (start_ev) state_d = ST_RUN;
                end
                ST_DONE: begin
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= ST_IDLE;
            presc_q   <= '0;
            tick_q    <= 1'b0;
            clr_q     <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            tick_q    <= tick_d;
            clr_q     <= clr_d;
            running_q <= (state_d == ST_RUN);
        end
    end

    assign bus.tick_en   = tick_q;
    assign bus.clr_pulse = clr_q;
    assign bus.running   = running_q;
    assign bus.state     = state_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// ----------------------------------------------------------------------------
// tb_timer_ctrl
// Directed bench: CLK_HZ=10, TICK_HZ=1 (DIV=10), DB_CYCLES=4. dut_w runs with
// WRAP=1, dut_s with WRAP=0; both see the same key / at_max stimulus.
// Debounce latency with these parameters: a key driven low just after edge e
// gives a press pulse after edge e+6 and the state change after edge e+7.
// ----------------------------------------------------------------------------
module tb_timer_ctrl;

    logic clk;
    logic rst_n;
    logic key_start_n;
    logic key_clr_n;
    logic at_max;

    int checks;
    int errors;

    timer_ctrl_if bus_w ();
    timer_ctrl_if bus_s ();

    assign bus_w.key_start_n = key_start_n;
    assign bus_w.key_clr_n   = key_clr_n;
    assign bus_w.at_max      = at_max;
    assign bus_s.key_start_n = key_start_n;
    assign bus_s.key_clr_n   = key_clr_n;
    assign bus_s.at_max      = at_max;

    timer_ctrl #(.CLK_HZ(10), .TICK_HZ(1), .DB_CYCLES(4), .WRAP(1'b1)) dut_w (
        .CLOCK_50 (clk),
        .RESET_N  (rst_n),
        .bus      (bus_w.slave)
    );

    timer_ctrl #(.CLK_HZ(10), .TICK_HZ(1), .DB_CYCLES(4), .WRAP(1'b0)) dut_s (
        .CLOCK_50 (clk),
        .RESET_N  (rst_n),
        .bus      (bus_s.slave)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Advance n rising edges, then sit 1 time unit past the edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        key_start_n = 1'b1;
        key_clr_n   = 1'b1;
        rst_n       = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(1);
    endtask

    // Hold the selected keys low long enough to debounce, then release.
    task automatic press(input bit start, input bit clr);
        if (start) key_start_n = 1'b0;
        if (clr)   key_clr_n   = 1'b0;
        step(6);
        key_start_n = 1'b1;
        key_clr_n   = 1'b1;
    endtask

    // Cycles until dut_w raises tick_en; returns max+1 if it never does.
    task automatic wait_tick(input int max, output int n);
        n = max + 1;
        for (int k = 1; k <= max; k++) begin
            step(1);
            if (bus_w.tick_en) begin
                n = k;
                break;
            end
        end
    endtask

    // ---------------- stimulus + checks ----------------
    initial begin
        int n;
        int cnt_a;
        int cnt_b;
        checks      = 0;
        errors      = 0;
        rst_n       = 1'b0;
        key_start_n = 1'b1;
        key_clr_n   = 1'b1;
        at_max      = 1'b0;
        step(2);
        check_eq("rst_state",   bus_w.state,     0);
        check_eq("rst_running", bus_w.running,   0);
        check_eq("rst_tick",    bus_w.tick_en,   0);
        check_eq("rst_clr",     bus_w.clr_pulse, 0);
        rst_n = 1'b1;
        step(1);

        // 1. held start key: one event, ticks every DIV cycles
        key_start_n = 1'b0;
        n = 99;
        for (int k = 1; k <= 20; k++) begin
            step(1);
            if (bus_w.state == 2'b01) begin
                n = k;
                break;
            end
        end
        check_eq("t1_enter_latency", n, 7);
        check_eq("t1_running", bus_w.running, 1);
        wait_tick(15, n);
        check_eq("t1_first_tick", n, 10);
        wait_tick(15, n);
        check_eq("t1_second_tick", n, 10);
        key_start_n = 1'b1;
        step(10);
        check_eq("t1_held_once", bus_w.state, 2'b01);

        // 2. bounce rejected, then a clean 6-cycle press gives one event
        apply_reset();
        for (int k = 0; k < 6; k++) begin
            key_start_n = k[0];
            step(2);
        end
        key_start_n = 1'b1;
        step(10);
        check_eq("t2_bounce_ignored", bus_w.state, 2'b00);
        press(1'b1, 1'b0);
        step(1);
        check_eq("t2_press_run", bus_w.state, 2'b01);
        step(12);
        check_eq("t2_single_event", bus_w.state, 2'b01);

        // 3. pause with prescaler=6, resume: next tick after 4 cycles
        wait_tick(15, n);
        check_eq("t3_sync_tick_seen", (n <= 10), 1);
        press(1'b1, 1'b0);
        step(1);
        check_eq("t3_paused", bus_w.state, 2'b10);
        check_eq("t3_paused_running", bus_w.running, 0);
        cnt_a = 0;
        for (int k = 0; k < 43; k++) begin
            step(1);
            if (bus_w.tick_en) cnt_a++;
        end
        check_eq("t3_no_tick_in_pause", cnt_a, 0);
        press(1'b1, 1'b0);
        step(1);
        check_eq("t3_resumed", bus_w.state, 2'b01);
        wait_tick(15, n);
        check_eq("t3_resume_tick", n, 4);

        // 4. clear and start together in RUN: clear wins
        step(4);
        press(1'b1, 1'b1);
        step(1);
        check_eq("t4_clr_pulse", bus_w.clr_pulse, 1);
        check_eq("t4_state_idle", bus_w.state, 2'b00);
        check_eq("t4_running", bus_w.running, 0);
        cnt_a = 0;
        cnt_b = 0;
        for (int k = 0; k < 25; k++) begin
            step(1);
            if (bus_w.tick_en)   cnt_a++;
            if (bus_w.clr_pulse) cnt_b++;
        end
        check_eq("t4_no_tick_after", cnt_a, 0);
        check_eq("t4_clr_one_cycle", cnt_b, 0);
        check_eq("t4_start_dropped", bus_w.state, 2'b00);

        // 5. WRAP=0 terminal count -> DONE (dut_s); WRAP=1 keeps ticking (dut_w)
        apply_reset();
        at_max = 1'b1;
        press(1'b1, 1'b0);
        step(1);
        check_eq("t5_run", bus_s.state, 2'b01);
        cnt_a = 0;
        for (int k = 0; k < 10; k++) begin
            step(1);
            if (bus_s.tick_en) cnt_a++;
        end
        check_eq("t5_no_tick_at_max", cnt_a, 0);
        check_eq("t5_done", bus_s.state, 2'b11);
        check_eq("t5_done_running", bus_s.running, 0);
        check_eq("t5_wrap_ticks", bus_w.tick_en, 1);
        step(6);
        press(1'b1, 1'b0);
        step(1);
        check_eq("t5_start_ignored", bus_s.state, 2'b11);
        step(6);
        press(1'b0, 1'b1);
        step(1);
        check_eq("t5_clear_idle", bus_s.state, 2'b00);
        check_eq("t5_clear_pulse", bus_s.clr_pulse, 1);
        at_max = 1'b0;

        // 6. asynchronous reset mid-RUN at prescaler=7
        apply_reset();
        press(1'b1, 1'b0);
        step(1);
        wait_tick(15, n);
        check_eq("t6_tick_before", n, 10);
        step(7);
        check_eq("t6_running_before", bus_w.running, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t6_async_state",   bus_w.state,     0);
        check_eq("t6_async_running", bus_w.running,   0);
        check_eq("t6_async_tick",    bus_w.tick_en,   0);
        check_eq("t6_async_clr",     bus_w.clr_pulse, 0);
        #2;
        rst_n = 1'b1;
        step(1);
        check_eq("t6_after_release", bus_w.state, 0);
        press(1'b1, 1'b0);
        step(1);
        check_eq("t6_restart_run", bus_w.state, 2'b01);
        wait_tick(15, n);
        check_eq("t6_restart_tick", n, 10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
